updown_seq_ctrl: RTL and testbench

Synchronous sequencer that drives a loadable up/down counter between programmable lower and upper limits.
- Supports one-shot up, one-shot down, ping-pong (N traversals) and free-run wrap modes.
- Uses a start/stop handshake with busy/done status.
- Sits between a control register block and any logic needing a bounded scan or step index, e.g. address sweeps or LED bar sequencing.

---
 rtl/updown_ctrl_pkg.sv | 16 +
 rtl/updown_core.sv | 32 +++
 rtl/updown_seq_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_updown_seq_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_ctrl_pkg.sv
// Shared types and constants for the up/down scan sequencer.
package updown_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_FREERUN  = 2'b11;

endpackage

// File: rtl/updown_core.sv
// Loadable up/down counter; load takes priority over a count step.
module updown_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = up ? q_q + 1'b1 : q_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/updown_seq_ctrl.sv
// Bounded up/down scan sequencer: one-shot, ping-pong and free-run wrap modes.
// Optional step prescaler enabled by defining PRESCALE_EN.
module updown_seq_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int PASS_W       = 4,
  parameter int PRESCALE_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  lo_lim,
  input  logic [WIDTH-1:0]  hi_lim,
  input  logic [PASS_W-1:0] npass,
  output logic [WIDTH-1:0]  cnt,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic              err
);

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [WIDTH-1:0]    lo_q, lo_d, hi_q, hi_d;
  logic [PASS_W-1:0]   npass_q, npass_d, pass_q, pass_d;
  logic                dir_q, dir_d, wrap_q, wrap_d, err_q, err_d;

  logic                core_load, core_en, core_up;
  logic [WIDTH-1:0]    core_load_val;
  logic                accept, step, last_pass;
  logic [PASS_W-1:0]   npass_eff;

  assign accept    = (state_q == IDLE) && start && !stop && (lo_lim <= hi_lim);
  assign npass_eff = (npass_q == '0) ? PASS_W'(1) : npass_q;
  assign last_pass = ((pass_q + 1'b1) == npass_eff);

`ifdef PRESCALE_EN
  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  logic [PW-1:0] presc_q, presc_d;
  logic          running;

  assign running = (state_q == RUN_UP) || (state_q == RUN_DOWN);
  assign step    = (presc_q == PW'(PRESCALE_DIV - 1));

  always_comb begin
    presc_d = presc_q;
    if (accept)       presc_d = '0;
    else if (running) presc_d = step ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end
`else
  // PRESCALE_DIV has no effect without the prescaler
  logic unused_prescale_div;
  assign unused_prescale_div = (PRESCALE_DIV != 0);
  assign step = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_UP;
      lo_q    <= '0;
      hi_q    <= '0;
      npass_q <= '0;
      pass_q  <= '0;
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      npass_q <= npass_d;
      pass_q  <= pass_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    npass_d       = npass_q;
    pass_d        = pass_q;
    dir_d         = dir_q;
    wrap_d        = 1'b0;
    err_d         = 1'b0;
    core_load     = 1'b0;
    core_load_val = lo_q;
    core_en       = 1'b0;
    core_up       = dir_q;

    case (state_q)
      IDLE: begin
        if (start && !stop && (lo_lim > hi_lim)) begin
          err_d = 1'b1;
        end else if (accept) begin
          mode_d    = mode;
          lo_d      = lo_lim;
          hi_d      = hi_lim;
          npass_d   = npass;
          pass_d    = '0;
          core_load = 1'b1;
          if (mode == MODE_DOWN) begin
            core_load_val = hi_lim;
            dir_d         = 1'b0;
            state_d       = RUN_DOWN;
          end else begin
            core_load_val = lo_lim;
            dir_d         = 1'b1;
            state_d       = RUN_UP;
          end
          // A zero-length range has nothing to scan, except in free-run
          if ((lo_lim == hi_lim) && (mode != MODE_FREERUN)) state_d = DONE;
        end
      end

      RUN_UP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (step) begin
          if (cnt < hi_q) begin
            core_en = 1'b1;
            core_up = 1'b1;
          end else begin
            case (mode_q)
              MODE_FREERUN: begin
                core_load     = 1'b1;
                core_load_val = lo_q;
                wrap_d        = 1'b1;
              end
              MODE_PINGPONG: begin
                pass_d = pass_q + 1'b1;
                if (last_pass) begin
                  state_d = DONE;
                end else begin
                  dir_d   = 1'b0;
                  state_d = RUN_DOWN;
                  core_en = 1'b1;
                  core_up = 1'b0;
                end
              end
              default: state_d = DONE;
            endcase
          end
        end
      end

      RUN_DOWN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (step) begin
          if (cnt > lo_q) begin
            core_en = 1'b1;
            core_up = 1'b0;
          end else if (mode_q == MODE_PINGPONG) begin
            pass_d = pass_q + 1'b1;
            if (last_pass) begin
              state_d = DONE;
            end else begin
              dir_d   = 1'b1;
              state_d = RUN_UP;
              core_en = 1'b1;
              core_up = 1'b1;
            end
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN_UP) || (state_q == RUN_DOWN);
    done = (state_q == DONE);
    dir  = dir_q;
    wrap = wrap_q;
    err  = err_q;
  end

  updown_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (core_load_val),
    .en       (core_en),
    .up       (core_up),
    .q        (cnt)
  );

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Scoreboard bench for updown_seq_ctrl: expected per-cycle outputs queued, then popped on each falling edge.
`timescale 1ns/1ps
module tb_updown_seq_ctrl;
  import updown_ctrl_pkg::*;

  localparam int WIDTH        = 4;
  localparam int PASS_W       = 4;
  localparam int PRESCALE_DIV = 4;
`ifdef PRESCALE_EN
  localparam int HOLD = PRESCALE_DIV;
`else
  localparam int HOLD = 1;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             dir;
    logic             busy;
    logic             done;
    logic             wrap;
    logic             err;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [WIDTH-1:0]  lo_lim = '0;
  logic [WIDTH-1:0]  hi_lim = '0;
  logic [PASS_W-1:0] npass = '0;
  logic [WIDTH-1:0]  cnt;
  logic              dir, busy, done, wrap, err;

  int   vectors = 0;
  int   miscompares = 0;
  obs_t sb[$];

  updown_seq_ctrl #(
    .WIDTH        (WIDTH),
    .PASS_W       (PASS_W),
    .PRESCALE_DIV (PRESCALE_DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .lo_lim (lo_lim),
    .hi_lim (hi_lim),
    .npass  (npass),
    .cnt    (cnt),
    .dir    (dir),
    .busy   (busy),
    .done   (done),
    .wrap   (wrap),
    .err    (err)
  );

  always #5 clk = ~clk;

  function automatic obs_t ev(input logic [WIDTH-1:0] c, input logic d, input logic b,
                              input logic dn, input logic w, input logic e);
    return {c, d, b, dn, w, e};
  endfunction

  function automatic obs_t sample();
    return {cnt, dir, busy, done, wrap, err};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("cnt=%0d dir=%0b busy=%0b done=%0b wrap=%0b err=%0b",
                     o.cnt, o.dir, o.busy, o.done, o.wrap, o.err);
  endfunction

  // One running value occupies HOLD cycles; a wrap pulse shows only on the first.
  function automatic void push_run(input logic [WIDTH-1:0] v, input logic d, input logic w);
    for (int i = 0; i < HOLD; i++) sb.push_back(ev(v, d, 1'b1, 1'b0, (i == 0) ? w : 1'b0, 1'b0));
  endfunction

  // Launch a command; afterwards scramble the limit inputs to prove they were latched.
  task automatic start_cmd(input logic [1:0] m, input int lo, input int hi, input int np);
    @(posedge clk); #1;
    mode = m; lo_lim = WIDTH'(lo); hi_lim = WIDTH'(hi); npass = PASS_W'(np); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lo_lim = WIDTH'($urandom); hi_lim = WIDTH'($urandom); npass = PASS_W'($urandom);
    mode = 2'($urandom);
  endtask

  task automatic test_reset();
    obs_t got, exp;
    sb.push_back(ev('0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    while (sb.size() > 0) begin
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL reset: got %s want %s", fmt(got), fmt(exp));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_up_oneshot();
    obs_t got, exp;
    for (int v = 3; v <= 6; v++) push_run(WIDTH'(v), 1'b1, 1'b0);
    sb.push_back(ev(4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    sb.push_back(ev(4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    start_cmd(MODE_UP, 3, 6, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL up_oneshot: got %s want %s", fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_pingpong(input int lo, input int hi, input int np);
    obs_t got, exp;
    int   v = lo;
    int   passes = 0;
    int   np_eff = (np == 0) ? 1 : np;
    logic d = 1'b1;
    push_run(WIDTH'(v), d, 1'b0);
    for (int k = 0; k < 200; k++) begin
      if (d && v < hi) v++;
      else if (!d && v > lo) v--;
      else begin
        passes++;
        if (passes == np_eff) break;
        d = !d;
        v = d ? v + 1 : v - 1;
      end
      push_run(WIDTH'(v), d, 1'b0);
    end
    sb.push_back(ev(WIDTH'(v), d, 1'b0, 1'b1, 1'b0, 1'b0));
    sb.push_back(ev(WIDTH'(v), d, 1'b0, 1'b0, 1'b0, 1'b0));
    start_cmd(MODE_PINGPONG, lo, hi, np);
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL pingpong np=%0d: got %s want %s", np, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_freerun_stop();
    obs_t got, exp;
    for (int v = 12; v <= 15; v++) push_run(WIDTH'(v), 1'b1, 1'b0);
    push_run(4'd12, 1'b1, 1'b1);
    sb.push_back(ev(4'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    start_cmd(MODE_FREERUN, 12, 15, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL freerun: got %s want %s", fmt(got), fmt(exp));
      end
    end
    stop = 1'b1;
    repeat (2) sb.push_back(ev(4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL freerun_stop: got %s want %s", fmt(got), fmt(exp));
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_err_and_start_stop();
    obs_t got, exp;
    sb.push_back(ev(4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    sb.push_back(ev(4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    start_cmd(MODE_UP, 9, 4, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL bad_limits: got %s want %s", fmt(got), fmt(exp));
      end
    end
    @(posedge clk); #1;
    mode = MODE_UP; lo_lim = 4'd1; hi_lim = 4'd5; start = 1'b1; stop = 1'b1;
    repeat (3) sb.push_back(ev(4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL start_with_stop: got %s want %s", fmt(got), fmt(exp));
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_lo_eq_hi();
    obs_t got, exp;
    sb.push_back(ev(4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    sb.push_back(ev(4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    start_cmd(MODE_UP, 7, 7, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL lo_eq_hi_oneshot: got %s want %s", fmt(got), fmt(exp));
      end
    end
    push_run(4'd5, 1'b1, 1'b0);
    push_run(4'd5, 1'b1, 1'b1);
    push_run(4'd5, 1'b1, 1'b1);
    start_cmd(MODE_FREERUN, 5, 5, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL lo_eq_hi_wrap: got %s want %s", fmt(got), fmt(exp));
      end
    end
    stop = 1'b1;
    sb.push_back(ev(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL lo_eq_hi_stop: got %s want %s", fmt(got), fmt(exp));
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    for (int v = 5; v >= 2; v--) push_run(WIDTH'(v), 1'b0, 1'b0);
    sb.push_back(ev(4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    start_cmd(MODE_DOWN, 2, 5, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL down_oneshot: got %s want %s", fmt(got), fmt(exp));
      end
    end
    // Start raised during DONE must wait for IDLE before it is taken.
    mode = MODE_UP; lo_lim = 4'd0; hi_lim = 4'd1; start = 1'b1;
    sb.push_back(ev(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL start_in_done: got %s want %s", fmt(got), fmt(exp));
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    push_run(4'd0, 1'b1, 1'b0);
    push_run(4'd1, 1'b1, 1'b0);
    sb.push_back(ev(4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    sb.push_back(ev(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL back_to_back: got %s want %s", fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_reset_midrun();
    obs_t got, exp;
    bit   found = 1'b0;
    start_cmd(MODE_UP, 2, 9, 0);
    for (int k = 0; k < 20 * HOLD; k++) begin
      @(negedge clk);
      if (cnt == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL reach_cnt5: got cnt=%0d want cnt=5 within %0d cycles", cnt, 20 * HOLD);
    end
    #2 rst = 1'b1;
    #1;
    sb.push_back(ev('0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    exp = sb.pop_front(); got = sample(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %s want %s", fmt(got), fmt(exp));
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) sb.push_back(ev('0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL idle_after_reset: got %s want %s", fmt(got), fmt(exp));
      end
    end
  endtask

`ifdef PRESCALE_EN
  task automatic test_prescale();
    obs_t got, exp;
    for (int v = 2; v >= 0; v--) push_run(WIDTH'(v), 1'b0, 1'b0);
    sb.push_back(ev(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    sb.push_back(ev(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    start_cmd(MODE_DOWN, 0, 2, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front(); got = sample(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL prescale_down: got %s want %s", fmt(got), fmt(exp));
      end
    end
  endtask
`endif

  initial begin
    $display("[TB] starting updown_seq_ctrl bench, step hold = %0d", HOLD);
    test_reset();
    test_up_oneshot();
    test_pingpong(1, 3, 3);
    test_pingpong(4, 6, 0);
    test_freerun_stop();
    test_err_and_start_stop();
    test_lo_eq_hi();
    test_back_to_back();
    test_reset_midrun();
`ifdef PRESCALE_EN
    test_prescale();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
